debounce_edge: RTL

- Consumes a raw, asynchronous, possibly bouncy single-bit input, such as a button or external strobe.
- Synchronises the input through a flip-flop chain, then qualifies it with a stability counter.
- Drives a clean registered level plus one-cycle rise/fall pulses.
- Sits directly downstream of the team's D flip-flop primitive, which it instantiates as the synchroniser stages, and upstream of control logic that needs glitch-free edges.

---
 rtl/debounce_edge_pkg.sv | 18 +
 rtl/debounce_edge_sync_chain.sv | 23 ++
 rtl/dff.sv | 16 +
 rtl/debounce_edge.sv | 83 ++++++++
 4 files changed

// File: rtl/debounce_edge_pkg.sv
// Shared state encoding and counter-width helper for the debounce_edge block.
package debounce_edge_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CHECK = 1'b1
    } state_t;

    // Bits needed to hold 0..n, never less than one.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < (n + 1))
            w++;
        return w;
    endfunction

endpackage

// File: rtl/debounce_edge_sync_chain.sv
// Metastability synchroniser: a plain chain of dff primitives, nothing between stages.
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stage;

    for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_stage
        if (i == 0) begin : g_first
            dff u_dff (.clk(clk), .rst(rst), .d(d), .q(stage[0]));
        end else begin : g_next
            dff u_dff (.clk(clk), .rst(rst), .d(stage[i-1]), .q(stage[i]));
        end
    end

    assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/dff.sv
// Single D flip-flop primitive with synchronous active-high clear.
module dff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= 1'b0;
        else
            q <= d;
    end

endmodule

// File: rtl/debounce_edge.sv
// Debouncer: synchronises a raw input, qualifies changes with a stability
// counter, and drives a clean level plus one-cycle rise/fall pulses.
module debounce_edge
    import debounce_edge_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic q_out,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int            CW   = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          s;

    sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk),
        .rst(rst),
        .d(d_in),
        .q(s)
    );

    // Commit is checked before the increment, so cnt never passes STABLE_CYCLES-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            q_out <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (s != q_out) begin
                        if (STABLE_CYCLES == 1) begin
                            q_out <= s;
                            rise  <= s;
                            fall  <= ~s;
                            cnt   <= '0;
                        end else begin
                            state <= ST_CHECK;
                            cnt   <= CW'(1);
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
                ST_CHECK: begin
                    if (s == q_out) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        q_out <= s;
                        rise  <= s;
                        fall  <= ~s;
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy = (state == ST_CHECK);

endmodule
